// File: rtl/fp16_sched_pkg.sv
// Shared types and helpers for the fp16 multiplier scheduler.
package fp16_sched_pkg;

  localparam int FP16_W   = 16;
  localparam int ID_MAX_W = 3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [FP16_W-1:0]   data;
  } rsp_entry_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fp16_mpy_sched_if.sv
// Operand request, multiplier and response signals of the fp16 scheduler.
interface fp16_mpy_sched_if
  import fp16_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IDW = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [FP16_W*NUM_REQ-1:0] req_a;
  logic [FP16_W*NUM_REQ-1:0] req_b;
  logic [FP16_W-1:0]         mpy_a;
  logic [FP16_W-1:0]         mpy_b;
  logic [FP16_W-1:0]         mpy_y;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [FP16_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mpy_y,
    input  req_ready, mpy_a, mpy_b, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mpy_y,
    output req_ready, mpy_a, mpy_b, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/fp16_sched_rsp_fifo.sv
// First-word-fall-through queue of tagged products; head is zero when empty.
module fp16_sched_rsp_fifo
  import fp16_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  rsp_entry_t       push_ent,
  input  logic             pop,
  output rsp_entry_t       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot being written, so push on full is legal alongside it.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ent;
  end

endmodule

// File: rtl/fp16_mpy_sched.sv
// Round-robin scheduler sharing one combinational fp16 multiplier among
// NUM_REQ requesters, with credit-limited issue and an in-order response queue.
module fp16_mpy_sched
  import fp16_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 2,
  parameter int DEPTH   = 4
) (
  input logic             clk,
  input logic             rst_n,
  fp16_mpy_sched_if.slave bus
);
  localparam int IDW   = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NDLY  = LAT - 1;

  logic [IDW-1:0]    rr_ptr, grant_id, id_p0, scan_idx;
  logic              grant_vld, vld_p0, pop;
  logic [FP16_W-1:0] a_p0, b_p0;
  rsp_entry_t        ent_p1 [NDLY];
  logic [NDLY-1:0]   vld_p1;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  rsp_entry_t        head;
  int unsigned       occupied;

  // Credits come from registered occupancy only, so a pop frees its slot next cycle.
  always_comb begin
    occupied = 32'(fifo_count) + 32'(vld_p0);
    for (int k = 0; k < NDLY; k++) occupied += 32'(vld_p1[k]);
  end

  // Descending offsets: the lowest offset from rr_ptr with a valid bit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    if (rst_n && occupied < DEPTH) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        scan_idx = IDW'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
        if (bus.req_valid[scan_idx]) begin
          grant_vld = 1'b1;
          grant_id  = scan_idx;
        end
      end
    end
  end

  assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;

  // Issue stage: registered operands drive the shared multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
    end else begin
      vld_p0    <= grant_vld;
      vld_p1[0] <= vld_p0;
      for (int k = 1; k < NDLY; k++) vld_p1[k] <= vld_p1[k-1];
      if (grant_vld) begin
        rr_ptr <= IDW'(rr_next(int'(grant_id), NUM_REQ));
        a_p0   <= bus.req_a[grant_id*FP16_W +: FP16_W];
        b_p0   <= bus.req_b[grant_id*FP16_W +: FP16_W];
      end
    end
  end

  // Capture stage plus LAT-2 delay stages feeding the response queue.
  always_ff @(posedge clk) begin
    if (grant_vld) id_p0 <= grant_id;
    ent_p1[0].id   <= ID_MAX_W'(id_p0);
    ent_p1[0].data <= bus.mpy_y;
    for (int k = 1; k < NDLY; k++) ent_p1[k] <= ent_p1[k-1];
  end

  assign pop = !fifo_empty && bus.rsp_ready;

  fp16_sched_rsp_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (vld_p1[NDLY-1]),
    .push_ent (ent_p1[NDLY-1]),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.mpy_a     = a_p0;
  assign bus.mpy_b     = b_p0;
  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_id    = head.id[IDW-1:0];
  assign bus.rsp_data  = head.data;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(vld_p1[NDLY-1] && fifo_full && !pop));
  a_head_id_range: assert property (@(posedge clk) disable iff (!rst_n)
    !fifo_empty |-> (32'(head.id) < NUM_REQ));

endmodule

// File: doc/fp16_mpy_sched.md
Name: fp16_mpy_sched

Overview:
Round-robin scheduler that shares one combinational fp16 multiplier (mpy_top: input_a, input_b -> mpy_output) among NUM_REQ requesters. Accepts operand pairs over valid/ready and drives the multiplier from registered operands. Returns each product on a single response channel, tagged with the requester ID. Sits between the accelerator's operand sources and the multiplier. mpy_top is instantiated beside this block, not inside it.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LAT, 2, cycles from request handshake to rsp_valid on an empty response queue (>=2)
DEPTH, 4, response queue depth; also the cap on in-flight plus queued operations (>=2)

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand pair valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  16*NUM_REQ  fp16 operand A; slice i belongs to requester i
req_b  in  16*NUM_REQ  fp16 operand B
mpy_a  out  16  to mpy_top.input_a
mpy_b  out  16  to mpy_top.input_b
mpy_y  in  16  from mpy_top.mpy_output (combinational)
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  clog2(NUM_REQ)  requester index of the product
rsp_data  out  16  fp16 product

Behaviour:
- Reset (async, rst_n=0): rr_ptr=0; pipeline valids cleared; queue empty; rsp_valid=0; req_ready=0; mpy_a=mpy_b=0; rsp_id=0; rsp_data=0. Asserting reset mid-operation discards in-flight and queued results; no response is emitted for them.
- Credits: credits = DEPTH - (in_flight + queue_count), computed from registered counts only. A pop this cycle frees its credit next cycle.
- Grant (combinational): when credits>0, grant the first index i, searching upward from rr_ptr with wrap, whose req_valid=1. Drive req_ready[i]=1 and all other bits 0. When credits=0, req_ready is all zero.
- req_ready must not depend on any req_valid bit other than the scan result. No handshake when all valid bits are 0.
- On handshake (req_valid[i] & req_ready[i]):
  - rr_ptr <= (i+1) mod NUM_REQ; rr_ptr is unchanged when there is no grant.
  - mpy_a <= req_a[i], mpy_b <= req_b[i], id <= i, stage-1 valid <= 1.
  - mpy_a/mpy_b hold their value when no new issue occurs.
- Pipeline:
  - Stage 1 (cycle after handshake): mpy_y is captured with its id into stage 2.
  - LAT-2 further delay stages follow.
  - The queue is written at the edge that ends cycle LAT-1 after the handshake.
  - Throughput is one operation per cycle.
- Response queue: FIFO, first-word fall-through.
  - rsp_valid = !empty; rsp_id and rsp_data show the head entry.
  - Pop on rsp_valid & rsp_ready.
  - Empty queue: rsp_valid rises exactly LAT cycles after the handshake edge.
  - Simultaneous push and pop on a full queue is legal; count is unchanged.
  - Overflow cannot occur under the credit rule. An assertion in RTL checks push & full & !pop never happens.
- Ordering: responses leave in issue order; there is no reordering across requesters.
- Fairness: with all requesters valid continuously and no backpressure, grants rotate 0,1,2,3,0...
- Requester rule: once req_valid is raised, the requester holds it and its operands stable until accepted. The scheduler does not check this.
- Data: operands and products are passed bit-exact; the scheduler does no arithmetic. Width is fixed at 16.

Decomposition:
- Package fp16_sched_pkg holds:
  - FP16_W=16.
  - ID_W function, clog2 of NUM_REQ.
  - A typedef for the {id, data} response entry.
  - A round-robin next-pointer function.
- Sub-module fp16_sched_rsp_fifo: parameterised DEPTH first-word-fall-through FIFO of response entries. Exposes count, full and empty.
- Top block holds the arbiter, credit counter and delay pipeline.

Test Plan:
- Single op, LAT=2: requester 2 sends a=BB67, b=F5CB with rsp_ready=1 -> one cycle of req_ready[2], then rsp_valid 2 cycles later with rsp_id=2, rsp_data=755C.
- Fairness: all 4 valid continuously, operand pairs (522C,87E6), (6DA0,AB89), (2C52,E687), (BB67,F5CB) -> grant order 0,1,2,3,0 and responses 9E18, DD4C, D70D, 755C in order with matching ids.
- Backpressure, DEPTH=4: rsp_ready=0 and requester 0 streaming -> exactly 4 accepted, then req_ready=0. One pop -> next accept one cycle later. No loss or duplication.
- Full queue with pop and new push landing in the same cycle -> count stays 4 and data order is preserved.
- Reset mid-operation: assert rst_n=0 with 2 ops in flight -> all outputs return to reset values immediately, and no stale response follows release.
- Idle: all req_valid=0 for 10 cycles -> req_ready=0, rsp_valid=0, rr_ptr unchanged, mpy_a/mpy_b held.
